// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC engine: mode encoding, FSM state
// type, the arctangent table and the gain-compensation constant.
package cordic_pkg;

   // Operating modes carried on the mode input.
   localparam logic MODE_VECT = 1'b0;   // drive Y to 0, accumulate angle in Z
   localparam logic MODE_ROT  = 1'b1;   // drive Z to 0, rotate (X, Y)

   // Sequencer states. COMP is only visited when gain compensation is built.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ITERATE = 2'd1,
      COMP    = 2'd2,
      DONE    = 2'd3
   } state_e;

   // atan(2^-i) scaled by 2^30. Beyond i = 9 the angle equals 2^-i to well
   // under one LSB at this scale, so the tail is a plain power of two.
   function automatic longint atan_ref(input int i);
      case (i)
         0:       return 64'sd843314857;
         1:       return 64'sd497837829;
         2:       return 64'sd263043837;
         3:       return 64'sd133525159;
         4:       return 64'sd67021687;
         5:       return 64'sd33543516;
         6:       return 64'sd16775851;
         7:       return 64'sd8388437;
         8:       return 64'sd4194283;
         9:       return 64'sd2097149;
         default: return (i < 30) ? (64'sd1 <<< (30 - i)) : 64'sd0;
      endcase
   endfunction

   // round(atan(2^-i) * 2^frac); frac must be in 1..29.
   function automatic longint cordic_atan(input int i, input int frac);
      longint t;
      t = atan_ref(i);
      return (t + (64'sd1 <<< (29 - frac))) >>> (30 - frac);
   endfunction

   // round(2^frac / K), K = prod_{i<iter} sqrt(1 + 2^-2i).
   // K^2 is accumulated at 2^30 scale, then K * 2^30 comes from an integer
   // square root of K^2 * 2^60, which keeps everything in 64-bit integers.
   function automatic longint cordic_kinv(input int iter, input int frac);
      longint unsigned p;
      longint unsigned v;
      longint unsigned r;
      longint unsigned b;
      longint unsigned num;
      p = 64'd1 << 30;
      for (int i = 0; i < iter; i++) begin
         p = p + (p >> (2 * i));
      end
      v = p << 30;
      r = 64'd0;
      b = 64'd1 << 62;
      while (b > v) b = b >> 2;
      while (b != 64'd0) begin
         if (v >= r + b) begin
            v = v - (r + b);
            r = (r >> 1) + b;
         end else begin
            r = r >> 1;
         end
         b = b >> 2;
      end
      num = 64'd1 << (frac + 30);
      return longint'((num + (r >> 1)) / r);
   endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, one entry per micro-rotation index.
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int ITER = 12,
   parameter int FRAC = 11,
   parameter int ZW   = 17,
   parameter int IW   = 4
) (
   input  logic        [IW-1:0] idx_i,
   output logic signed [ZW-1:0] atan_o
);

   logic signed [ZW-1:0] table_w [ITER];

   for (genvar k = 0; k < ITER; k++) begin : g_entry
      assign table_w[k] = ZW'(cordic_atan(k, FRAC));
   end

   // Select the entry for the current index; indices past the table read 0.
   always_comb begin
      // NOTE: default assignment first so every path drives atan_o (no latch).
      atan_o = '0;
      for (int k = 0; k < ITER; k++) begin
         if (idx_i == IW'(k)) atan_o = table_w[k];
      end
   end

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative multi-mode CORDIC engine: one shift-add stage reused for ITER
// micro-rotations, with start/done handshake and saturated outputs.
// Optional gain compensation is compiled in with `define CORDIC_GAIN_COMP_EN.
module cordic_iter_engine
   import cordic_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = 11,
   parameter int ITER  = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    mode,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   input  logic signed [WIDTH-1:0] z_in,
   output logic                    busy,
   output logic                    done,
   output logic signed [WIDTH-1:0] x_out,
   output logic signed [WIDTH-1:0] y_out,
   output logic signed [WIDTH-1:0] z_out
);

   // X/Y carry two guard bits for gain growth, Z one for angle accumulation.
   localparam int XW = WIDTH + 2;
   localparam int ZW = WIDTH + 1;
   localparam int IW = $clog2(ITER + 1);
   localparam logic [IW-1:0] LAST_I = IW'(ITER - 1);

   localparam logic signed [XW-1:0] SAT_MAX = XW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
   localparam logic signed [XW-1:0] SAT_MIN = XW'(-(64'sd1 <<< (WIDTH - 1)));

   state_e                 state_q;
   logic                   mode_q;
   logic signed [XW-1:0]   x_q, y_q;
   logic signed [ZW-1:0]   z_q;
   logic        [IW-1:0]   i_q;
   logic                   busy_q, done_q;
   logic signed [WIDTH-1:0] x_out_q, y_out_q, z_out_q;

   // Next-state values of one micro-rotation.
   logic signed [XW-1:0]   x_d, y_d;
   logic signed [ZW-1:0]   z_d;
   logic signed [XW-1:0]   x_sh, y_sh;
   logic signed [ZW-1:0]   atan_w;
   logic                   sub_dir;

   // Clamp a guard-extended value to the signed WIDTH-bit range.
   function automatic logic signed [WIDTH-1:0] sat_val(input logic signed [XW-1:0] v);
      if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
      else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
      else                  return v[WIDTH-1:0];
   endfunction

   cordic_atan_rom #(
      .ITER (ITER),
      .FRAC (FRAC),
      .ZW   (ZW),
      .IW   (IW)
   ) u_atan_rom (
      .idx_i  (i_q),
      .atan_o (atan_w)
   );

   // One micro-rotation from the current (pre-update) X, Y, Z.
   always_comb begin
      x_sh = x_q >>> i_q;
      y_sh = y_q >>> i_q;
      // sub_dir: X -= Y>>>i, Y += X>>>i, Z -= atan(i); otherwise the opposite.
      case (mode_q)
         MODE_VECT: sub_dir = y_q[XW-1];
         MODE_ROT:  sub_dir = ~z_q[ZW-1];
      endcase
      if (sub_dir) begin
         x_d = x_q - y_sh;
         y_d = y_q + x_sh;
         z_d = z_q - atan_w;
      end else begin
         x_d = x_q + y_sh;
         y_d = y_q - x_sh;
         z_d = z_q + atan_w;
      end
   end

`ifdef CORDIC_GAIN_COMP_EN
   localparam int KW = FRAC + 2;
   localparam int PW = XW + KW;
   localparam logic signed [KW-1:0] KINV = KW'(cordic_kinv(ITER, FRAC));
   localparam logic signed [PW-1:0] HALF = PW'(64'sd1 <<< (FRAC - 1));

   logic signed [PW-1:0] x_prod, y_prod;
   logic signed [XW-1:0] x_comp_d, y_comp_d;

   // Scale X and Y by 1/K, rounding to nearest; saturation happens in DONE.
   always_comb begin
      x_prod   = PW'(x_q) * PW'(KINV);
      y_prod   = PW'(y_q) * PW'(KINV);
      x_comp_d = XW'((x_prod + HALF) >>> FRAC);
      y_comp_d = XW'((y_prod + HALF) >>> FRAC);
   end
`endif

   // Sequencer, datapath registers and registered handshake/outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: datapath and output registers are reset as well, so the
         // outputs read 0 after reset and an aborted operation leaves no trace.
         state_q <= IDLE;
         mode_q  <= MODE_VECT;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         i_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         x_out_q <= '0;
         y_out_q <= '0;
         z_out_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from
         // pre-edge values, which is what makes X/Y/Z updates simultaneous.
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  mode_q  <= mode;
                  x_q     <= XW'(x_in);
                  y_q     <= XW'(y_in);
                  z_q     <= ZW'(z_in);
                  i_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ITERATE;
               end
            end
            ITERATE: begin
               x_q <= x_d;
               y_q <= y_d;
               z_q <= z_d;
               i_q <= i_q + IW'(1);
               if (i_q == LAST_I) begin
`ifdef CORDIC_GAIN_COMP_EN
                  state_q <= COMP;
`else
                  state_q <= DONE;
`endif
               end
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
               x_q     <= x_comp_d;
               y_q     <= y_comp_d;
               state_q <= DONE;
            end
`endif
            DONE: begin
               x_out_q <= sat_val(x_q);
               y_out_q <= sat_val(y_q);
               z_out_q <= sat_val(XW'(z_q));
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               i_q     <= '0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign x_out = x_out_q;
   assign y_out = y_out_q;
   assign z_out = z_out_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed self-checking bench for cordic_iter_engine. Expected results come
// from an ideal floating-point CORDIC reference (gain K, exact angles) and are
// queued at start, then popped and compared within tolerance at done.
module tb_cordic_iter_engine;
   import cordic_pkg::*;

   localparam int WIDTH = 16;
   localparam int FRAC  = 11;
   localparam int ITER  = 12;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int LAT = ITER + 2;
`else
   localparam int LAT = ITER + 1;
`endif

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    start = 1'b0;
   logic                    mode = 1'b0;
   logic signed [WIDTH-1:0] x_in = '0, y_in = '0, z_in = '0;
   logic                    busy, done;
   logic signed [WIDTH-1:0] x_out, y_out, z_out;

   always #5 clk = ~clk;

   cordic_iter_engine #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC),
      .ITER  (ITER)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mode  (mode),
      .x_in  (x_in),
      .y_in  (y_in),
      .z_in  (z_in),
      .busy  (busy),
      .done  (done),
      .x_out (x_out),
      .y_out (y_out),
      .z_out (z_out)
   );

   typedef struct {
      int x;  int y;  int z;
      int tx; int ty; int tz;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_errors = 0;

   task automatic check(input string tag, input int obs, input int exp, input int tol);
      int diff;
      diff = obs - exp;
      if (diff < 0) diff = -diff;
      n_checks++;
      assert ((diff <= tol) === 1'b1)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   // Round to an output word; a clamped value must match exactly.
   function automatic void fix(input real r, input int tol, output int v, output int t);
      if (r > 32767.0) begin
         v = 32767;  t = 0;
      end else if (r < -32768.0) begin
         v = -32768; t = 0;
      end else begin
         v = int'(r); t = tol;
      end
   endfunction

   function automatic void model(input logic m, input int x, input int y, input int z,
                                 input int tx, input int ty, input int tz, output exp_t e);
      real g, sc, xr, yr, zr, ang;
      g  = 1.0;
`ifndef CORDIC_GAIN_COMP_EN
      for (int i = 0; i < ITER; i++) g = g * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`endif
      sc = 2.0 ** FRAC;
      if (m == MODE_VECT) begin
         xr = g * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
         yr = 0.0;
         zr = real'(z) + $atan2(real'(y), real'(x)) * sc;
      end else begin
         ang = real'(z) / sc;
         xr  = g * (real'(x) * $cos(ang) - real'(y) * $sin(ang));
         yr  = g * (real'(x) * $sin(ang) + real'(y) * $cos(ang));
         zr  = 0.0;
      end
      fix(xr, tx, e.x, e.tx);
      fix(yr, ty, e.y, e.ty);
      fix(zr, tz, e.z, e.tz);
   endfunction

   // Drive one start pulse from a falling edge; operands are scrambled right
   // after the accepting edge.
   task automatic issue(input logic m, input int x, input int y, input int z,
                        input int tx, input int ty, input int tz,
                        input string tag, input bit push);
      exp_t e;
      mode  = m;
      x_in  = 16'(x);
      y_in  = 16'(y);
      z_in  = 16'(z);
      start = 1'b1;
      if (push) begin
         model(m, x, y, z, tx, ty, tz, e);
         sb_q.push_back(e);
         tag_q.push_back(tag);
      end
      @(negedge clk);
      start = 1'b0;
      mode  = ~m;
      x_in  = 16'($urandom);
      y_in  = 16'($urandom);
      z_in  = 16'($urandom);
   endtask

   // Wait (bounded) for done, check latency/busy, then pop and compare.
   task automatic wait_done(input int exp_lat);
      int    k;
      bit    busy_ok;
      exp_t  e;
      string tag;
      k       = 0;
      busy_ok = (busy === 1'b1);
      while (done !== 1'b1 && k < 4 * LAT) begin
         @(negedge clk);
         k++;
         if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
      end
      if (tag_q.size() == 0) begin
         check("scoreboard_empty", 0, 1, 0);
      end else begin
         e   = sb_q.pop_front();
         tag = tag_q.pop_front();
         check({tag, ".latency"}, k, exp_lat, 0);
         check({tag, ".busy_during"}, int'(busy_ok), 1, 0);
         check({tag, ".busy_at_done"}, int'(busy), 0, 0);
         check({tag, ".x"}, int'(x_out), e.x, e.tx);
         check({tag, ".y"}, int'(y_out), e.y, e.ty);
         check({tag, ".z"}, int'(z_out), e.z, e.tz);
      end
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (done === 1'b1) n++;
      end
   endtask

   initial begin
      int n_done;

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset.x", int'(x_out), 0, 0);
      check("reset.y", int'(y_out), 0, 0);
      check("reset.z", int'(z_out), 0, 0);
      check("reset.busy", int'(busy), 0, 0);
      check("reset.done", int'(done), 0, 0);
      rst = 1'b1;
      @(negedge clk);

      // Vectoring and rotation reference points.
      issue(MODE_VECT,  2048,  2048,     0, 6,  4, 3, "vect_45",     1'b1); wait_done(LAT);
      @(negedge clk);
      issue(MODE_VECT,  2048, -2048,     0, 6,  4, 3, "vect_m45",    1'b1); wait_done(LAT);
      @(negedge clk);
      issue(MODE_ROT,   1244,     0,  1072, 4,  4, 2, "rot_30",      1'b1); wait_done(LAT);
      @(negedge clk);
      issue(MODE_ROT,   1244,     0, -1072, 4,  4, 2, "rot_m30",     1'b1); wait_done(LAT);
      @(negedge clk);
      issue(MODE_VECT,  1024,  2048,     0, 6,  4, 3, "vect_steep",  1'b1); wait_done(LAT);
      @(negedge clk);
      issue(MODE_VECT,  2048,  2048,   500, 6,  4, 3, "vect_zoff",   1'b1); wait_done(LAT);
      @(negedge clk);
      issue(MODE_ROT,   1000,     0,     0, 4,  4, 2, "rot_zero",    1'b1); wait_done(LAT);
      @(negedge clk);

      // Saturation at both rails.
      issue(MODE_VECT, 16000, 16000,     0, 6, 24, 3, "sat_xpos",    1'b1); wait_done(LAT);
      @(negedge clk);
      issue(MODE_VECT,  2048,  2048, 32767, 6,  4, 3, "sat_zpos",    1'b1); wait_done(LAT);
      @(negedge clk);
      issue(MODE_VECT,  2048, -2048, -32768, 6, 4, 3, "sat_zneg",    1'b1); wait_done(LAT);
      @(negedge clk);
      issue(MODE_ROT, -20000,     0,     0, 6, 60, 2, "sat_xneg",    1'b1); wait_done(LAT);
      @(negedge clk);

      // start while busy is ignored and produces no second done.
      issue(MODE_VECT,  2048,  2048,     0, 6,  4, 3, "busy_ign",    1'b1);
      repeat (4) @(negedge clk);
      mode = MODE_ROT; x_in = 16'(100); y_in = 16'(0); z_in = 16'(0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(LAT - 5);
      count_dones(2 * LAT, n_done);
      check("busy_ign.extra_done", n_done, 0, 0);

      // start in the done cycle is accepted.
      issue(MODE_ROT,   1244,     0,  1072, 4,  4, 2, "b2b_first",   1'b1); wait_done(LAT);
      issue(MODE_VECT,  2048, -2048,     0, 6,  4, 3, "b2b_second",  1'b1); wait_done(LAT);
      @(negedge clk);

      // Reset mid-operation clears everything and aborts without done.
      issue(MODE_VECT,  2048,  2048,     0, 6,  4, 3, "abort",       1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort.x", int'(x_out), 0, 0);
      check("abort.y", int'(y_out), 0, 0);
      check("abort.z", int'(z_out), 0, 0);
      check("abort.busy", int'(busy), 0, 0);
      check("abort.done", int'(done), 0, 0);
      @(negedge clk);
      rst = 1'b1;
      count_dones(3 * LAT, n_done);
      check("abort.no_done", n_done, 0, 0);

      // Engine works again after the abort.
      @(negedge clk);
      issue(MODE_ROT,   1244,     0, -1072, 4,  4, 2, "post_reset",  1'b1); wait_done(LAT);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
